// File: rtl/sdram_arbiter.sv
// Two-requester arbiter in front of the sdram_controller host port.
// Gates traffic until config done, latches one owner's command per transaction.
module sdram_arbiter #(
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_addr,
    input  logic        i_wr_en,
    input  logic [1:0]  i_bytesel,
    input  logic [15:0] i_wdata,
    output logic [15:0] i_rdata,
    output logic        i_compl,
    input  logic [31:0] d_addr,
    input  logic        d_wr_en,
    input  logic [1:0]  d_bytesel,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_compl,
    output logic [31:0] h_addr,
    output logic        h_wr_en,
    output logic [1:0]  h_bytesel,
    output logic [15:0] h_wdata,
    input  logic [15:0] h_rdata,
    input  logic        h_compl,
    input  logic        h_config_done,
    output logic        busy
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 2;
    localparam bit          FP = (FIXED_PRIORITY != 0);

    typedef enum logic [1:0] {
        ST_CONFIG = 2'd0,
        ST_IDLE   = 2'd1,
        ST_BUSY   = 2'd2
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   addr_q;
    logic            wr_en_q;
    logic [BW-1:0]   bytesel_q;
    logic [DW-1:0]   wdata_q;
    logic            owner_d_q;   // 1 = data port owns the transaction
    logic            last_d_q;    // 1 = data port was granted last

    logic            i_req_c;
    logic            d_req_c;
    logic            grant_d_c;
    logic            busy_c;

    assign i_req_c = (i_bytesel != BW'(0));
    assign d_req_c = (d_bytesel != BW'(0));

    // Winner selection; only meaningful when at least one request is pending.
    always_comb begin
        grant_d_c = d_req_c;
        if (i_req_c && d_req_c) begin
            grant_d_c = FP ? 1'b1 : ~last_d_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CONFIG;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            bytesel_q <= '0;
            wdata_q   <= '0;
            owner_d_q <= 1'b0;
            last_d_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_CONFIG: begin
                    if (h_config_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (i_req_c || d_req_c) begin
                        addr_q    <= grant_d_c ? d_addr    : i_addr;
                        wr_en_q   <= grant_d_c ? d_wr_en   : i_wr_en;
                        bytesel_q <= grant_d_c ? d_bytesel : i_bytesel;
                        wdata_q   <= grant_d_c ? d_wdata   : i_wdata;
                        owner_d_q <= grant_d_c;
                        last_d_q  <= grant_d_c;
                        state_q   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (h_compl) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_CONFIG;
            endcase
        end
    end

    assign busy_c    = (state_q == ST_BUSY);
    assign busy      = busy_c;
    assign h_addr    = addr_q;
    assign h_wr_en   = wr_en_q;
    assign h_wdata   = wdata_q;
    // Command is withdrawn in the completion cycle so the controller never sees a repeat.
    assign h_bytesel = (busy_c && !h_compl) ? bytesel_q : BW'(0);

    assign i_compl   = h_compl && busy_c && !owner_d_q;
    assign d_compl   = h_compl && busy_c &&  owner_d_q;
    assign i_rdata   = h_rdata;
    assign d_rdata   = h_rdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: round-robin instance [0] and fixed-priority instance [1],
// directed scenarios plus random traffic checked against a transaction-level model.
module tb_sdram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a   [2];
    logic [31:0] i_addr_a  [2];
    logic        i_wr_a    [2];
    logic [1:0]  i_bs_a    [2];
    logic [15:0] i_wd_a    [2];
    logic [15:0] i_rd_a    [2];
    logic        i_cp_a    [2];
    logic [31:0] d_addr_a  [2];
    logic        d_wr_a    [2];
    logic [1:0]  d_bs_a    [2];
    logic [15:0] d_wd_a    [2];
    logic [15:0] d_rd_a    [2];
    logic        d_cp_a    [2];
    logic [31:0] h_addr_a  [2];
    logic        h_wr_a    [2];
    logic [1:0]  h_bs_a    [2];
    logic [15:0] h_wd_a    [2];
    logic [15:0] h_rd_a    [2];
    logic        h_cp_a    [2];
    logic        cfg_a     [2];
    logic        busy_a    [2];

    int total = 0;
    int bad   = 0;
    bit exp_last_d [2];

    sdram_arbiter #(.FIXED_PRIORITY(0)) u_rr (
        .clk(clk), .rst_n(rst_n_a[0]),
        .i_addr(i_addr_a[0]), .i_wr_en(i_wr_a[0]), .i_bytesel(i_bs_a[0]), .i_wdata(i_wd_a[0]),
        .i_rdata(i_rd_a[0]), .i_compl(i_cp_a[0]),
        .d_addr(d_addr_a[0]), .d_wr_en(d_wr_a[0]), .d_bytesel(d_bs_a[0]), .d_wdata(d_wd_a[0]),
        .d_rdata(d_rd_a[0]), .d_compl(d_cp_a[0]),
        .h_addr(h_addr_a[0]), .h_wr_en(h_wr_a[0]), .h_bytesel(h_bs_a[0]), .h_wdata(h_wd_a[0]),
        .h_rdata(h_rd_a[0]), .h_compl(h_cp_a[0]), .h_config_done(cfg_a[0]), .busy(busy_a[0])
    );

    sdram_arbiter #(.FIXED_PRIORITY(1)) u_fp (
        .clk(clk), .rst_n(rst_n_a[1]),
        .i_addr(i_addr_a[1]), .i_wr_en(i_wr_a[1]), .i_bytesel(i_bs_a[1]), .i_wdata(i_wd_a[1]),
        .i_rdata(i_rd_a[1]), .i_compl(i_cp_a[1]),
        .d_addr(d_addr_a[1]), .d_wr_en(d_wr_a[1]), .d_bytesel(d_bs_a[1]), .d_wdata(d_wd_a[1]),
        .d_rdata(d_rd_a[1]), .d_compl(d_cp_a[1]),
        .h_addr(h_addr_a[1]), .h_wr_en(h_wr_a[1]), .h_bytesel(h_bs_a[1]), .h_wdata(h_wd_a[1]),
        .h_rdata(h_rd_a[1]), .h_compl(h_cp_a[1]), .h_config_done(cfg_a[1]), .busy(busy_a[1])
    );

    task automatic clear_inputs(input int k);
        i_addr_a[k] = '0; i_wr_a[k] = 1'b0; i_bs_a[k] = '0; i_wd_a[k] = '0;
        d_addr_a[k] = '0; d_wr_a[k] = 1'b0; d_bs_a[k] = '0; d_wd_a[k] = '0;
        h_rd_a[k] = '0; h_cp_a[k] = 1'b0;
    endtask

    // Leaves the DUT in CONFIG at a falling edge, reset released.
    task automatic do_reset(input int k);
        @(negedge clk);
        rst_n_a[k] = 1'b0;
        h_cp_a[k]  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n_a[k] = 1'b1;
        exp_last_d[k] = 1'b1;
    endtask

    task automatic wait_grant(input int k, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (h_bs_a[k] != 2'b00) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rst_n_a[k] = 1'b0;
            i_bs_a[k] = 2'b11; i_addr_a[k] = 32'hdead_beef; d_bs_a[k] = 2'b01;
            @(negedge clk);
            total++;
            if (h_bs_a[k] !== 2'b00 || busy_a[k] !== 1'b0 || i_cp_a[k] !== 1'b0 || d_cp_a[k] !== 1'b0)
                begin bad++; $display("FAIL reset_ctrl[%0d] h_bytesel=%b busy=%b icp=%b dcp=%b expected 00 0 0 0",
                    k, h_bs_a[k], busy_a[k], i_cp_a[k], d_cp_a[k]); end
            total++;
            if (h_addr_a[k] !== 32'h0 || h_wr_a[k] !== 1'b0 || h_wd_a[k] !== 16'h0)
                begin bad++; $display("FAIL reset_cmd[%0d] addr=%h wr=%b wdata=%h expected zeros",
                    k, h_addr_a[k], h_wr_a[k], h_wd_a[k]); end
            clear_inputs(k);
            rst_n_a[k] = 1'b1;
        end
    endtask

    task automatic test_config();
        cfg_a[0] = 1'b0;
        do_reset(0);
        i_addr_a[0] = 32'h40; i_bs_a[0] = 2'b11;
        begin
            bit leaked = 1'b0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (h_bs_a[0] !== 2'b00 || busy_a[0] !== 1'b0) leaked = 1'b1;
            end
            total++;
            if (leaked) begin bad++; $display("FAIL config_gate h_bytesel went %b expected 00 throughout", 2'b11); end
        end
        cfg_a[0] = 1'b1;
        @(negedge clk);
        total++;
        if (h_bs_a[0] !== 2'b00) begin bad++; $display("FAIL config_idle h_bytesel=%b expected 00", h_bs_a[0]); end
        @(negedge clk);
        total++;
        if (h_bs_a[0] !== 2'b11) begin bad++; $display("FAIL config_grant h_bytesel=%b expected 11", h_bs_a[0]); end
        exp_last_d[0] = 1'b0;
        // Config done dropping after startup must not gate traffic.
        cfg_a[0] = 1'b0;
        h_cp_a[0] = 1'b1; h_rd_a[0] = 16'h1234;
        #1;
        total++;
        if (i_cp_a[0] !== 1'b1 || d_cp_a[0] !== 1'b0)
            begin bad++; $display("FAIL config_compl icp=%b dcp=%b expected 1 0", i_cp_a[0], d_cp_a[0]); end
        @(negedge clk);
        h_cp_a[0] = 1'b0; i_bs_a[0] = 2'b00;
        d_addr_a[0] = 32'h88; d_bs_a[0] = 2'b01;
        @(negedge clk);
        total++;
        if (h_bs_a[0] !== 2'b01 || h_addr_a[0] !== 32'h88)
            begin bad++; $display("FAIL config_drop_ignored h_bytesel=%b addr=%h expected 01 00000088", h_bs_a[0], h_addr_a[0]); end
        h_cp_a[0] = 1'b1;
        @(negedge clk);
        h_cp_a[0] = 1'b0; d_bs_a[0] = 2'b00;
        cfg_a[0] = 1'b1;
        clear_inputs(0);
    endtask

    task automatic test_single_write();
        bit ok;
        bit stray = 1'b0;
        do_reset(0);
        d_addr_a[0] = 32'h100; d_wr_a[0] = 1'b1; d_wd_a[0] = 16'h55aa; d_bs_a[0] = 2'b11;
        wait_grant(0, ok);
        total++;
        if (!ok || h_addr_a[0] !== 32'h100 || h_wr_a[0] !== 1'b1 || h_wd_a[0] !== 16'h55aa || busy_a[0] !== 1'b1)
            begin bad++; $display("FAIL write_cmd ok=%b addr=%h wr=%b wdata=%h busy=%b expected 1 00000100 1 55aa 1",
                ok, h_addr_a[0], h_wr_a[0], h_wd_a[0], busy_a[0]); end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (i_cp_a[0] !== 1'b0 || d_cp_a[0] !== 1'b0) stray = 1'b1;
        end
        total++;
        if (stray) begin bad++; $display("FAIL write_early_compl saw compl=1 expected 0 before h_compl"); end
        @(negedge clk);
        h_cp_a[0] = 1'b1; h_rd_a[0] = 16'h0bad;
        #1;
        total++;
        if (d_cp_a[0] !== 1'b1 || i_cp_a[0] !== 1'b0 || h_bs_a[0] !== 2'b00)
            begin bad++; $display("FAIL write_compl dcp=%b icp=%b h_bytesel=%b expected 1 0 00",
                d_cp_a[0], i_cp_a[0], h_bs_a[0]); end
        @(negedge clk);
        h_cp_a[0] = 1'b0; d_bs_a[0] = 2'b00;
        #1;
        total++;
        if (d_cp_a[0] !== 1'b0 || busy_a[0] !== 1'b0)
            begin bad++; $display("FAIL write_after dcp=%b busy=%b expected 0 0", d_cp_a[0], busy_a[0]); end
        clear_inputs(0);
    endtask

    task automatic test_round_robin();
        bit ok;
        bit exp_d;
        do_reset(0);
        i_addr_a[0] = 32'h1000; i_bs_a[0] = 2'b01;
        d_addr_a[0] = 32'h2000; d_bs_a[0] = 2'b10; d_wr_a[0] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_d = (t % 2) == 1;
            wait_grant(0, ok);
            total++;
            if (!ok || h_addr_a[0] !== (exp_d ? 32'h2000 : 32'h1000))
                begin bad++; $display("FAIL rr_grant%0d ok=%b addr=%h expected %h",
                    t, ok, h_addr_a[0], exp_d ? 32'h2000 : 32'h1000); end
            repeat (2) @(negedge clk);
            h_cp_a[0] = 1'b1;
            #1;
            total++;
            if (d_cp_a[0] !== exp_d || i_cp_a[0] !== !exp_d)
                begin bad++; $display("FAIL rr_compl%0d icp=%b dcp=%b expected %b %b",
                    t, i_cp_a[0], d_cp_a[0], !exp_d, exp_d); end
            @(negedge clk);
            h_cp_a[0] = 1'b0;
            #1;
            total++;
            if (busy_a[0] !== 1'b0 || h_bs_a[0] !== 2'b00)
                begin bad++; $display("FAIL rr_gap%0d busy=%b h_bytesel=%b expected 0 00", t, busy_a[0], h_bs_a[0]); end
        end
        exp_last_d[0] = 1'b1;
        clear_inputs(0);
    endtask

    task automatic test_fixed_priority();
        bit ok;
        do_reset(1);
        i_addr_a[1] = 32'h3000; i_bs_a[1] = 2'b11;
        d_addr_a[1] = 32'h4000; d_bs_a[1] = 2'b11;
        for (int t = 0; t < 3; t++) begin
            wait_grant(1, ok);
            total++;
            if (!ok || h_addr_a[1] !== 32'h4000)
                begin bad++; $display("FAIL fp_grant%0d ok=%b addr=%h expected 00004000", t, ok, h_addr_a[1]); end
            @(negedge clk);
            h_cp_a[1] = 1'b1;
            #1;
            total++;
            if (d_cp_a[1] !== 1'b1 || i_cp_a[1] !== 1'b0)
                begin bad++; $display("FAIL fp_compl%0d icp=%b dcp=%b expected 0 1", t, i_cp_a[1], d_cp_a[1]); end
            @(negedge clk);
            h_cp_a[1] = 1'b0;
            if (t == 2) d_bs_a[1] = 2'b00;
        end
        @(negedge clk);
        total++;
        if (h_bs_a[1] !== 2'b11 || h_addr_a[1] !== 32'h3000)
            begin bad++; $display("FAIL fp_i_after_drop h_bytesel=%b addr=%h expected 11 00003000", h_bs_a[1], h_addr_a[1]); end
        h_cp_a[1] = 1'b1;
        #1;
        total++;
        if (i_cp_a[1] !== 1'b1) begin bad++; $display("FAIL fp_i_compl icp=%b expected 1", i_cp_a[1]); end
        @(negedge clk);
        h_cp_a[1] = 1'b0;
        clear_inputs(1);
    endtask

    task automatic test_latch_read();
        bit ok;
        do_reset(0);
        i_addr_a[0] = 32'h2; i_wr_a[0] = 1'b0; i_bs_a[0] = 2'b11;
        wait_grant(0, ok);
        @(negedge clk);
        i_addr_a[0] = 32'hffff; i_bs_a[0] = 2'b00;
        @(negedge clk);
        total++;
        if (!ok || h_addr_a[0] !== 32'h2 || h_bs_a[0] !== 2'b11 || h_wr_a[0] !== 1'b0)
            begin bad++; $display("FAIL latch_cmd ok=%b addr=%h bytesel=%b wr=%b expected 1 00000002 11 0",
                ok, h_addr_a[0], h_bs_a[0], h_wr_a[0]); end
        h_cp_a[0] = 1'b1; h_rd_a[0] = 16'h0003;
        #1;
        total++;
        if (i_cp_a[0] !== 1'b1 || i_rd_a[0] !== 16'h0003 || d_cp_a[0] !== 1'b0)
            begin bad++; $display("FAIL read_return icp=%b rdata=%h dcp=%b expected 1 0003 0",
                i_cp_a[0], i_rd_a[0], d_cp_a[0]); end
        @(negedge clk);
        h_cp_a[0] = 1'b0;
        clear_inputs(0);
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset(0);
        d_addr_a[0] = 32'h300; d_bs_a[0] = 2'b11;
        wait_grant(0, ok);
        @(negedge clk);
        rst_n_a[0] = 1'b0;
        @(negedge clk);
        total++;
        if (!ok || h_bs_a[0] !== 2'b00 || busy_a[0] !== 1'b0 || d_cp_a[0] !== 1'b0)
            begin bad++; $display("FAIL reset_mid ok=%b h_bytesel=%b busy=%b dcp=%b expected 1 00 0 0",
                ok, h_bs_a[0], busy_a[0], d_cp_a[0]); end
        d_bs_a[0] = 2'b00;
        rst_n_a[0] = 1'b1;
        exp_last_d[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        h_cp_a[0] = 1'b1; h_rd_a[0] = 16'hcafe;
        #1;
        total++;
        if (i_cp_a[0] !== 1'b0 || d_cp_a[0] !== 1'b0)
            begin bad++; $display("FAIL stray_compl icp=%b dcp=%b expected 0 0", i_cp_a[0], d_cp_a[0]); end
        @(negedge clk);
        h_cp_a[0] = 1'b0;
        #1;
        total++;
        if (busy_a[0] !== 1'b0 || h_bs_a[0] !== 2'b00)
            begin bad++; $display("FAIL stray_state busy=%b h_bytesel=%b expected 0 00", busy_a[0], h_bs_a[0]); end
        clear_inputs(0);
    endtask

    // Random traffic: model keeps pending commands per port and applies the grant rule.
    task automatic test_random(input int k, input int n_txn);
        bit          ok;
        bit          ip, dp, win_d, drop_early;
        logic [31:0] ia, da;
        logic        iw, dw;
        logic [1:0]  ib, db;
        logic [15:0] iwd, dwd, rd;
        int          lat;
        ip = 1'b0; dp = 1'b0;
        ia = '0; da = '0; iw = 1'b0; dw = 1'b0; ib = '0; db = '0; iwd = '0; dwd = '0;
        do_reset(k);
        @(negedge clk);
        for (int t = 0; t < n_txn; t++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1'b1; ia = 32'($urandom); iw = 1'($urandom); ib = 2'($urandom_range(1, 3)); iwd = 16'($urandom);
            end
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp = 1'b1; da = 32'($urandom); dw = 1'($urandom); db = 2'($urandom_range(1, 3)); dwd = 16'($urandom);
            end
            if (!ip && !dp) begin
                ip = 1'b1; ia = 32'($urandom); iw = 1'($urandom); ib = 2'($urandom_range(1, 3)); iwd = 16'($urandom);
            end
            i_addr_a[k] = ia; i_wr_a[k] = iw; i_bs_a[k] = ip ? ib : 2'b00; i_wd_a[k] = iwd;
            d_addr_a[k] = da; d_wr_a[k] = dw; d_bs_a[k] = dp ? db : 2'b00; d_wd_a[k] = dwd;
            if (ip && dp) win_d = (k == 1) ? 1'b1 : !exp_last_d[k];
            else          win_d = dp;
            @(negedge clk);
            wait_grant(k, ok);
            total++;
            if (!ok || h_addr_a[k] !== (win_d ? da : ia) || h_wr_a[k] !== (win_d ? dw : iw) ||
                h_bs_a[k] !== (win_d ? db : ib) || h_wd_a[k] !== (win_d ? dwd : iwd))
                begin bad++; $display("FAIL rand%0d_cmd%0d ok=%b addr=%h wr=%b bs=%b wd=%h expected owner_d=%b addr=%h wr=%b bs=%b wd=%h",
                    k, t, ok, h_addr_a[k], h_wr_a[k], h_bs_a[k], h_wd_a[k],
                    win_d, win_d ? da : ia, win_d ? dw : iw, win_d ? db : ib, win_d ? dwd : iwd); end
            exp_last_d[k] = win_d;
            drop_early = ($urandom_range(0, 3) == 0);
            lat = $urandom_range(0, 4);
            for (int c = 0; c < lat; c++) begin
                @(negedge clk);
                if (drop_early) begin
                    if (win_d) d_bs_a[k] = 2'b00; else i_bs_a[k] = 2'b00;
                end
            end
            rd = 16'($urandom);
            h_cp_a[k] = 1'b1; h_rd_a[k] = rd;
            #1;
            total++;
            if (d_cp_a[k] !== win_d || i_cp_a[k] !== !win_d || (win_d ? d_rd_a[k] : i_rd_a[k]) !== rd || h_bs_a[k] !== 2'b00)
                begin bad++; $display("FAIL rand%0d_compl%0d icp=%b dcp=%b rdata=%h h_bytesel=%b expected %b %b %h 00",
                    k, t, i_cp_a[k], d_cp_a[k], win_d ? d_rd_a[k] : i_rd_a[k], h_bs_a[k], !win_d, win_d, rd); end
            @(negedge clk);
            h_cp_a[k] = 1'b0;
            if (win_d) begin dp = 1'b0; d_bs_a[k] = 2'b00; end
            else       begin ip = 1'b0; i_bs_a[k] = 2'b00; end
            #1;
            total++;
            if (busy_a[k] !== 1'b0)
                begin bad++; $display("FAIL rand%0d_gap%0d busy=%b expected 0", k, t, busy_a[k]); end
        end
        @(negedge clk);
        clear_inputs(k);
        // Drain a transaction that may have been granted from a still-pending loser.
        if (busy_a[k]) begin
            h_cp_a[k] = 1'b1;
            @(negedge clk);
            h_cp_a[k] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            clear_inputs(k);
            cfg_a[k] = 1'b1;
            rst_n_a[k] = 1'b0;
            exp_last_d[k] = 1'b1;
        end
        test_reset();
        test_config();
        test_single_write();
        test_round_robin();
        test_fixed_priority();
        test_latch_read();
        test_reset_mid();
        test_random(0, 30);
        test_random(1, 30);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-requester arbiter that shares the single host port of sdram_controller between an instruction fetch port (i_*) and a data port (d_*).
- Holds off all traffic until the controller reports configuration done.
- Grants one requester at a time, round-robin or fixed-priority, and latches that requester's command for the whole transaction.
- Routes completion and read data back to the owner only.

Parameters:
- FIXED_PRIORITY, 0, 0 = round-robin between i and d; 1 = d always wins a simultaneous request.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- i_addr  input  32  instruction requester byte address
- i_wr_en  input  1  instruction requester write enable
- i_bytesel  input  2  instruction requester byte select; nonzero = request pending
- i_wdata  input  16  instruction requester write data
- i_rdata  output  16  read data to instruction requester
- i_compl  output  1  one-cycle completion to instruction requester
- d_addr  input  32  data requester byte address
- d_wr_en  input  1  data requester write enable
- d_bytesel  input  2  data requester byte select; nonzero = request pending
- d_wdata  input  16  data requester write data
- d_rdata  output  16  read data to data requester
- d_compl  output  1  one-cycle completion to data requester
- h_addr  output  32  controller address
- h_wr_en  output  1  controller write enable
- h_bytesel  output  2  controller byte select; nonzero = command active
- h_wdata  output  16  controller write data
- h_rdata  input  16  controller read data, valid when h_compl=1
- h_compl  input  1  controller one-cycle completion
- h_config_done  input  1  controller initialisation finished
- busy  output  1  transaction in flight (state BUSY)

Behaviour:
- Request definition: a requester has a request pending when its bytesel != 2'b00.
- Requester obligation: hold addr, wr_en, bytesel and wdata stable until its compl; it may drop bytesel in the compl cycle.
- States:
  - CONFIG (reset state): remain here while h_config_done=0; go to IDLE when it is 1.
  - IDLE:
    - No request: stay.
    - One request: grant it.
    - Both requesting: FIXED_PRIORITY=1 grants d; FIXED_PRIORITY=0 grants the port that was not last granted.
    - On grant: latch the winner's addr, wr_en, bytesel and wdata into the command registers, record the owner and last_grant, and go to BUSY.
  - BUSY: drive the latched command on h_*. When h_compl=1, stay in BUSY for that cycle and go to IDLE next cycle.
- Latency: a request seen in IDLE at edge N appears on h_bytesel from edge N+1. Between two transactions there is a minimum of one IDLE cycle.
- h_bytesel:
  - latched bytesel in BUSY when h_compl=0;
  - 2'b00 in the h_compl cycle;
  - 2'b00 in CONFIG and IDLE.
- h_addr, h_wr_en, h_wdata: always the command register contents.
- Completion routing: i_compl = h_compl && BUSY && owner==i; d_compl likewise for d. Both are combinational and occur in the same cycle as h_compl.
- Read data: i_rdata = d_rdata = h_rdata, combinational. Valid only when the respective compl=1.
- h_compl while in CONFIG or IDLE is ignored: no compl to either port and no state change.
- Requester drops bytesel mid-transaction: no effect. The latched command continues, and compl is still delivered to the owner.
- Non-owner request during BUSY: it waits, and is arbitrated in the next IDLE cycle.
- h_config_done falls to 0 after startup: ignored. CONFIG is entered only via reset.
- Reset values:
  - state=CONFIG; command registers all 0; h_bytesel=2'b00; busy=0; i_compl=d_compl=0.
  - last_grant=d, so the first round-robin tie goes to i.
- Reset mid-transaction: the transaction is abandoned and no compl is issued. The controller is reset with the same rst_n.

Test Plan:
- Config gating: hold h_config_done=0 for 50 cycles with i_bytesel=2'b11 -> h_bytesel stays 2'b00. Raise h_config_done -> h_bytesel=2'b11 two cycles later (IDLE cycle, then BUSY).
- Single write: d_addr=32'h100, d_wr_en=1, d_wdata=16'h55aa, d_bytesel=2'b11. Controller model returns h_compl after 6 cycles -> d_compl pulses once, i_compl stays 0, h_bytesel=2'b00 in the compl cycle.
- Round-robin tie, FIXED_PRIORITY=0: i and d request continuously from reset -> grants alternate i, d, i, d. Each grant is separated by at least one IDLE cycle.
- Fixed priority, FIXED_PRIORITY=1: both request continuously -> d granted every transaction and i never granted. Drop d -> i granted in the next IDLE.
- Command latching and read return: i_addr=32'h2 read. Change i_addr to 32'hffff and i_bytesel to 2'b00 one cycle after grant -> h_addr stays 32'h2. Controller returns h_rdata=16'h0003 with h_compl -> i_compl=1 and i_rdata=16'h0003 in the same cycle.
- Reset mid-transaction and stray h_compl: assert rst_n=0 while BUSY -> next cycle h_bytesel=2'b00, busy=0, no compl. Pulse h_compl in IDLE -> no i_compl/d_compl.
